// File: rtl/axi_lite_pkg.sv
// Shared constants and address-decode helpers for the AXI4-Lite register file.
// Decode helpers take a zero-extended 64-bit address, so they work for any ADDR_W up to 64.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [63:0] addr_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   function automatic int addr_index(input addr_t addr, input int lsb, input int idx_w);
      return int'((addr >> lsb) & ((addr_t'(1) << idx_w) - addr_t'(1)));
   endfunction

   // Any address bit above the index field makes the access out of range.
   function automatic logic addr_in_range(input addr_t addr, input int lsb, input int idx_w,
                                          input int num_regs);
      return ((addr >> (lsb + idx_w)) == '0) && (addr_index(addr, lsb, idx_w) < num_regs);
   endfunction

endpackage

// File: rtl/axi_lite_hold_slot.sv
// One-entry valid/ready holding register: it accepts a beat while empty and
// keeps it until the consumer pulses i_take.
module axi_lite_hold_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   input  logic             i_take
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   // NOTE: the payload is not reset; it is only ever observed while r_full is set.
   always_ff @(posedge clk_i) begin
      if (i_valid && !r_full) r_data <= i_data;
   end

   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, read-only status slots,
// per-register write pulses and SLVERR decoding. AW and W are buffered independently.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int                  DATA_W   = 32,
   parameter int                  ADDR_W   = 32,
   parameter int                  NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [ADDR_W-1:0]          write_addr,
   input  logic [2:0]                 write_prot,
   input  logic                       write_addr_valid,
   output logic                       write_addr_ready,
   input  logic [DATA_W-1:0]          write_data,
   input  logic [DATA_W/8-1:0]        write_strb,
   input  logic                       write_data_valid,
   output logic                       write_data_ready,
   input  logic                       write_resp_ready,
   output logic [1:0]                 write_resp,
   output logic                       write_resp_valid,
   input  logic [ADDR_W-1:0]          read_addr,
   input  logic [2:0]                 read_prot,
   input  logic                       read_addr_valid,
   output logic                       read_addr_ready,
   input  logic                       read_data_ready,
   output logic [DATA_W-1:0]          read_data,
   output logic [1:0]                 read_resp,
   output logic                       read_data_valid,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   input  logic [NUM_REGS*DATA_W-1:0] status_i,
   output logic [NUM_REGS-1:0]        wr_pulse_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = clog2(STRB_W);
   localparam int IDX_W  = clog2(NUM_REGS);

   logic [ADDR_W-1:0]        w_aw_addr;
   logic [DATA_W+STRB_W-1:0] w_w_payload;
   logic [DATA_W-1:0]        w_wdata;
   logic [STRB_W-1:0]        w_strb;
   logic                     w_aw_full, w_w_full, w_commit, w_wr_ok;
   logic [IDX_W-1:0]         w_wr_idx, w_rd_idx;
   logic                     w_ar_hs, w_rd_in_range;
   logic [DATA_W-1:0]        w_rd_value;
   logic                     w_unused;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_pulse;
   logic                r_bvalid, r_rvalid;
   logic [1:0]          r_bresp, r_rresp;
   logic [DATA_W-1:0]   r_rdata;

   assign w_unused = ^{write_prot, read_prot};

   axi_lite_hold_slot #(.WIDTH(ADDR_W)) u_aw_slot (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_data(write_addr), .i_valid(write_addr_valid), .o_ready(write_addr_ready),
      .o_data(w_aw_addr), .o_full(w_aw_full), .i_take(w_commit)
   );

   axi_lite_hold_slot #(.WIDTH(DATA_W + STRB_W)) u_w_slot (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_data({write_strb, write_data}), .i_valid(write_data_valid), .o_ready(write_data_ready),
      .o_data(w_w_payload), .o_full(w_w_full), .i_take(w_commit)
   );

   assign {w_strb, w_wdata} = w_w_payload;

   // A pending B response blocks the next commit, so the slots stay full meanwhile.
   assign w_commit = w_aw_full && w_w_full && !r_bvalid;
   assign w_wr_idx = IDX_W'(addr_index(addr_t'(w_aw_addr), LSB, IDX_W));
   assign w_wr_ok  = addr_in_range(addr_t'(w_aw_addr), LSB, IDX_W, NUM_REGS) && !RO_MASK[w_wr_idx];

   assign w_ar_hs       = read_addr_valid && !r_rvalid;
   assign w_rd_idx      = IDX_W'(addr_index(addr_t'(read_addr), LSB, IDX_W));
   assign w_rd_in_range = addr_in_range(addr_t'(read_addr), LSB, IDX_W, NUM_REGS);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_rd_value = '0;
      if (w_rd_in_range) begin
         w_rd_value = RO_MASK[w_rd_idx] ? status_i[w_rd_idx*DATA_W +: DATA_W] : r_regs[w_rd_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_pulse <= '0;
      end else begin
         r_pulse <= '0;
         if (w_commit && w_wr_ok) begin
            r_pulse[w_wr_idx] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
               if (w_strb[b]) r_regs[w_wr_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (write_resp_ready) begin
         r_bvalid <= 1'b0;
      end
   end

   // The AR edge samples the array before any same-edge commit lands.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_value;
         r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (read_data_ready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
   end

   assign write_resp       = r_bresp;
   assign write_resp_valid = r_bvalid;
   assign read_addr_ready  = !r_rvalid;
   assign read_data        = r_rdata;
   assign read_resp        = r_rresp;
   assign read_data_valid  = r_rvalid;
   assign wr_pulse_o       = r_pulse;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile (DATA_W=32, NUM_REGS=8, RO_MASK=8'h80):
// directed vector table, hand-timed corner sequences, and random traffic against an array model.
module tb_axi_lite_regfile;

   logic         clk_i, rst_i;
   logic [31:0]  write_addr, write_data, read_addr, read_data;
   logic [2:0]   write_prot, read_prot;
   logic [3:0]   write_strb;
   logic         write_addr_valid, write_addr_ready, write_data_valid, write_data_ready;
   logic         write_resp_ready, write_resp_valid, read_addr_valid, read_addr_ready;
   logic         read_data_ready, read_data_valid;
   logic [1:0]   write_resp, read_resp;
   logic [255:0] regs_o, status_i;
   logic [7:0]   wr_pulse_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs   [8];
   logic [31:0] m_status [8];

   axi_lite_regfile #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(8), .RO_MASK(8'h80)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .write_addr(write_addr), .write_prot(write_prot), .write_addr_valid(write_addr_valid),
      .write_addr_ready(write_addr_ready),
      .write_data(write_data), .write_strb(write_strb), .write_data_valid(write_data_valid),
      .write_data_ready(write_data_ready),
      .write_resp_ready(write_resp_ready), .write_resp(write_resp), .write_resp_valid(write_resp_valid),
      .read_addr(read_addr), .read_prot(read_prot), .read_addr_valid(read_addr_valid),
      .read_addr_ready(read_addr_ready),
      .read_data_ready(read_data_ready), .read_data(read_data), .read_resp(read_resp),
      .read_data_valid(read_data_valid),
      .regs_o(regs_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: 4-byte registers, byte address space of 32 bytes -------
   function automatic logic [1:0] m_wr_resp(input logic [31:0] a);
      return (a < 32'h20 && a[4:2] != 3'd7) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [7:0] m_pulse(input logic [31:0] a);
      return (m_wr_resp(a) == 2'b00) ? 8'(1 << a[4:2]) : 8'h00;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m_wr_resp(a) == 2'b00) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_regs[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      if (a >= 32'h20)          begin d = 32'h0;              r = 2'b10; end
      else if (a[4:2] == 3'd7)  begin d = m_status[7];        r = 2'b00; end
      else                      begin d = m_regs[a[4:2]];     r = 2'b00; end
   endtask

   function automatic logic [255:0] m_flat();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = m_regs[i];
      return f;
   endfunction

   task automatic drive_status();
      for (int i = 0; i < 8; i++) status_i[i*32 +: 32] = m_status[i];
   endtask

   // ---------------- bus tasks: all driving and sampling happens on the falling edge ----------
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [7:0] pulse,
                            output int stalls, output int b_lat);
      bit aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, got_b = 0;
      int t = 0;
      stalls = 0; b_lat = -1; resp = 2'bxx; pulse = 8'hxx;
      write_resp_ready = 1'b1;
      while (!(aw_done && w_done) && t < 50) begin
         if (aw_hs) begin write_addr_valid = 1'b0; aw_done = 1; aw_hs = 0; end
         if (w_hs)  begin write_data_valid = 1'b0; w_done  = 1; w_hs  = 0; end
         if (!aw_done && !write_addr_valid && t >= aw_dly) begin
            write_addr = addr; write_addr_valid = 1'b1;
         end
         if (!w_done && !write_data_valid && t >= w_dly) begin
            write_data = data; write_strb = strb; write_data_valid = 1'b1;
         end
         if (!aw_done && !write_addr_ready) stalls++;
         if (!w_done && !write_data_ready)  stalls++;
         if (write_addr_valid && write_addr_ready) aw_hs = 1;
         if (write_data_valid && write_data_ready) w_hs  = 1;
         if (!(aw_done && w_done)) begin @(negedge clk_i); t++; end
      end
      check("write handshake completed", {255'd0, aw_done && w_done}, 256'd1);
      for (int k = 0; k < 20 && !got_b; k++) begin
         @(negedge clk_i);
         if (write_resp_valid) begin got_b = 1; resp = write_resp; pulse = wr_pulse_o; b_lat = k; end
      end
      check("B response arrived", {255'd0, got_b}, 256'd1);
      @(negedge clk_i);
      check("wr_pulse lasts one cycle", {248'd0, wr_pulse_o}, 256'd0);
   endtask

   task automatic read_txn(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
      bit got = 0;
      data = 32'hx; resp = 2'bxx; lat = -1;
      read_data_ready = 1'b1;
      read_addr = addr; read_addr_valid = 1'b1;
      for (int k = 0; k < 20 && !read_addr_ready; k++) @(negedge clk_i);
      @(negedge clk_i);
      read_addr_valid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (read_data_valid) begin got = 1; data = read_data; resp = read_resp; lat = k; end
         else @(negedge clk_i);
      end
      check("R response arrived", {255'd0, got}, 256'd1);
      @(negedge clk_i);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  exp_resp;
      logic [7:0]  exp_pulse;
   } wvec_t;

   wvec_t vecs [8];

   initial begin
      logic [1:0]  resp, eresp;
      logic [7:0]  pulse;
      logic [31:0] rdata, edata;
      int          stalls, lat;

      vecs[0] = '{32'h04,  32'hDEADBEEF, 4'hF,    0, 0, 2'b00, 8'h02};
      vecs[1] = '{32'h08,  32'hFFFFFFFF, 4'hF,    0, 0, 2'b00, 8'h04};
      vecs[2] = '{32'h08,  32'h11223344, 4'b0101, 3, 0, 2'b00, 8'h04};
      vecs[3] = '{32'h1C,  32'h12345678, 4'hF,    0, 2, 2'b10, 8'h00};
      vecs[4] = '{32'h20,  32'h12345678, 4'hF,    1, 1, 2'b10, 8'h00};
      vecs[5] = '{32'h10C, 32'hA5A5A5A5, 4'hF,    0, 0, 2'b10, 8'h00};
      vecs[6] = '{32'h0F,  32'h0BADF00D, 4'hF,    2, 0, 2'b00, 8'h08};
      vecs[7] = '{32'h18,  32'h55AA55AA, 4'b0000, 0, 0, 2'b00, 8'h40};

      for (int i = 0; i < 8; i++) begin m_regs[i] = 32'h0; m_status[i] = 32'h0; end
      m_status[7] = 32'hCAFE0001;
      m_status[3] = 32'h33333333;
      drive_status();
      write_addr = 0; write_prot = 0; write_addr_valid = 0;
      write_data = 0; write_strb = 0; write_data_valid = 0; write_resp_ready = 1;
      read_addr = 0;  read_prot = 3'b111; read_addr_valid = 0; read_data_ready = 1;
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // reset state
      check("reset regs_o", regs_o, 256'd0);
      check("reset readies", {253'd0, write_addr_ready, write_data_ready, read_addr_ready}, 256'h7);
      check("reset valids/pulse", {246'd0, write_resp_valid, read_data_valid, wr_pulse_o}, 256'd0);
      check("reset outputs", {220'd0, write_resp, read_resp, read_data}, 256'd0);

      // directed vector table
      for (int v = 0; v < 8; v++) begin
         write_txn(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly, vecs[v].w_dly,
                   resp, pulse, stalls, lat);
         m_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
         check($sformatf("vec%0d bresp", v), {254'd0, resp}, {254'd0, vecs[v].exp_resp});
         check($sformatf("vec%0d pulse", v), {248'd0, pulse}, {248'd0, vecs[v].exp_pulse});
         check($sformatf("vec%0d ready stalls", v), 256'(stalls), 256'd0);
         check($sformatf("vec%0d B latency", v), 256'(lat), 256'd0);
         check($sformatf("vec%0d regs_o", v), regs_o, m_flat());
         read_txn(vecs[v].addr, rdata, resp, lat);
         m_read(vecs[v].addr, edata, eresp);
         check($sformatf("vec%0d read data", v), {224'd0, rdata}, {224'd0, edata});
         check($sformatf("vec%0d read resp", v), {254'd0, resp}, {254'd0, eresp});
         check($sformatf("vec%0d R latency", v), 256'(lat), 256'd0);
      end
      check("reg1 DEADBEEF", {224'd0, regs_o[63:32]}, {224'd0, 32'hDEADBEEF});
      check("reg2 strobe merge", {224'd0, regs_o[95:64]}, {224'd0, 32'hFF22FF44});

      // B stalled: second write buffered but not committed until B completes
      write_resp_ready = 1'b0;
      write_addr = 32'h0C; write_data = 32'h01010101; write_strb = 4'hF;
      write_addr_valid = 1'b1; write_data_valid = 1'b1;
      @(negedge clk_i);
      write_addr_valid = 1'b0; write_data_valid = 1'b0;
      @(negedge clk_i);
      m_write(32'h0C, 32'h01010101, 4'hF);
      check("stall first commit", {254'd0, write_resp_valid, write_resp == 2'b00}, 256'h3);
      check("stall first regs_o", regs_o, m_flat());
      write_addr = 32'h10; write_data = 32'h02020202; write_strb = 4'hF;
      write_addr_valid = 1'b1; write_data_valid = 1'b1;
      check("stall second accepted", {254'd0, write_addr_ready, write_data_ready}, 256'h3);
      @(negedge clk_i);
      write_addr_valid = 1'b0; write_data_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall c%0d readies low", c), {254'd0, write_addr_ready, write_data_ready}, 256'd0);
         check($sformatf("stall c%0d B held", c), {253'd0, write_resp_valid, write_resp}, 256'h4);
         check($sformatf("stall c%0d no commit", c), regs_o, m_flat());
         @(negedge clk_i);
      end
      write_resp_ready = 1'b1;
      @(negedge clk_i);
      check("stall B cleared", {255'd0, write_resp_valid}, 256'd0);
      check("stall no commit on B edge", regs_o, m_flat());
      @(negedge clk_i);
      m_write(32'h10, 32'h02020202, 4'hF);
      check("stall second commit", {255'd0, write_resp_valid}, 256'd1);
      check("stall second regs_o", regs_o, m_flat());
      check("stall second pulse", {248'd0, wr_pulse_o}, 256'h10);
      @(negedge clk_i);
      check("stall readies restored", {254'd0, write_addr_ready, write_data_ready}, 256'h3);

      // same-edge AR and commit to register 0; R held for 4 cycles
      m_read(32'h0, edata, eresp);
      read_data_ready = 1'b0;
      write_addr = 32'h00; write_data = 32'h5; write_strb = 4'hF;
      write_addr_valid = 1'b1; write_data_valid = 1'b1;
      @(negedge clk_i);
      write_addr_valid = 1'b0; write_data_valid = 1'b0;
      read_addr = 32'h00; read_addr_valid = 1'b1;
      @(negedge clk_i);
      read_addr_valid = 1'b0;
      m_write(32'h0, 32'h5, 4'hF);
      check("collision read old value", {223'd0, read_data_valid, read_data}, {223'd0, 1'b1, edata});
      check("collision commit landed", regs_o, m_flat());
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         check($sformatf("R hold c%0d", c), {221'd0, read_data_valid, read_resp, read_data},
               {221'd0, 1'b1, 2'b00, edata});
      end
      read_data_ready = 1'b1;
      @(negedge clk_i);
      check("R cleared", {255'd0, read_data_valid}, 256'd0);
      read_txn(32'h0, rdata, resp, lat);
      check("collision reread", {224'd0, rdata}, {224'd0, 32'h5});

      // random traffic against the model
      for (int i = 0; i < 8; i++) m_status[i] = $urandom;
      drive_status();
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a, d;
         logic [3:0]  s;
         a = 32'($urandom_range(0, 39));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(5, 31));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, stalls, lat);
            check($sformatf("rnd%0d bresp a=%0h", n, a), {254'd0, resp}, {254'd0, m_wr_resp(a)});
            check($sformatf("rnd%0d pulse a=%0h", n, a), {248'd0, pulse}, {248'd0, m_pulse(a)});
            m_write(a, d, s);
            check($sformatf("rnd%0d regs_o", n), regs_o, m_flat());
         end else begin
            read_txn(a, rdata, resp, lat);
            m_read(a, edata, eresp);
            check($sformatf("rnd%0d read a=%0h", n, a), {222'd0, resp, rdata}, {222'd0, eresp, edata});
         end
      end

      // reset with AW buffered and R pending
      read_data_ready = 1'b0;
      write_addr = 32'h04; write_addr_valid = 1'b1;
      read_addr = 32'h04; read_addr_valid = 1'b1;
      @(negedge clk_i);
      write_addr_valid = 1'b0; read_addr_valid = 1'b0;
      check("pre-reset AW buffered / R pending", {254'd0, write_addr_ready, read_data_valid}, 256'h1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      check("mid reset regs_o", regs_o, 256'd0);
      check("mid reset readies", {253'd0, write_addr_ready, write_data_ready, read_addr_ready}, 256'h7);
      check("mid reset valids/pulse", {246'd0, write_resp_valid, read_data_valid, wr_pulse_o}, 256'd0);
      check("mid reset outputs", {220'd0, write_resp, read_resp, read_data}, 256'd0);
      read_data_ready = 1'b1;
      write_txn(32'h14, 32'h600DF00D, 4'hF, 1, 0, resp, pulse, stalls, lat);
      m_write(32'h14, 32'h600DF00D, 4'hF);
      check("post-reset bresp", {254'd0, resp}, 256'd0);
      check("post-reset pulse", {248'd0, pulse}, 256'h20);
      check("post-reset regs_o", regs_o, m_flat());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

Parametrised AXI4-Lite slave register file; the next-generation control/status front end for our accelerator IPs, such as the AES-CTR core. Replaces per-IP hand-coded slave logic. Provides NUM_REGS registers of DATA_W bits with byte strobes, read-only status slots, per-register write pulses and SLVERR decoding. AW and W channels are accepted independently and buffered. Sits directly behind the AXI interconnect port inside each IP wrapper.

## Interface
- DATA_W, 32: bus and register width; 32 or 64.
- ADDR_W, 32: AXI address width.
- NUM_REGS, 8: register count, 2..256.
- RO_MASK, {NUM_REGS{1'b0}}: bit i = 1 makes register i read-only (status).
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous reset, active-high.
- write_addr / write_prot / write_addr_valid  in  ADDR_W / 3 / 1  AW channel; prot ignored.
- write_addr_ready  out  1  AW ready.
- write_data / write_strb / write_data_valid  in  DATA_W / DATA_W/8 / 1  W channel.
- write_data_ready  out  1  W ready.
- write_resp_ready  in  1  B ready.
- write_resp / write_resp_valid  out  2 / 1  B channel.
- read_addr / read_prot / read_addr_valid  in  ADDR_W / 3 / 1  AR channel; prot ignored.
- read_addr_ready  out  1  AR ready.
- read_data_ready  in  1  R ready.
- read_data / read_resp / read_data_valid  out  DATA_W / 2 / 1  R channel.
- regs_o  out  NUM_REGS*DATA_W  flattened register contents; register i at [i*DATA_W +: DATA_W].
- status_i  in  NUM_REGS*DATA_W  read value for RO registers; other slices unused.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on a successful commit to register i.

## Operation
- Decode: LSB = log2(DATA_W/8). Index = addr[LSB +: IDX_W], where IDX_W = clog2(NUM_REGS). Low LSB address bits are ignored.
- Out-of-range: index >= NUM_REGS, or any address bit above LSB+IDX_W is set. Response is SLVERR (2'b10). A write has no effect; a read returns data 0.
- Write to an RO register: SLVERR, no effect, no pulse.
- Write path: AW and W each have a one-entry holding slot. The slot ready signal is high iff that slot is empty. The two channels are accepted in either order, in the same cycle or in different cycles.
- Commit condition: both slots full and write_resp_valid == 0. On the commit edge:
  - byte lanes where strb = 1 are updated, and only those;
  - write_resp_valid is set with OKAY or SLVERR;
  - both slots are cleared.
- wr_pulse_o[i] is high the cycle after a commit with OKAY to register i, even when strb = 0.
- B response: write_resp_valid and write_resp are held until write_resp_ready; valid clears on the handshake edge.
- Read path: read_addr_ready = !read_data_valid. The AR handshake edge registers read_data/read_resp and sets read_data_valid. Values are held stable until read_data_ready. An RO slot returns status_i sampled at the AR edge.
- Read/write collision: if an AR handshake and a commit to the same register fall on the same edge, the read returns the pre-commit value.

## Timing
- Reset (rst_i high at an edge):
  - regs_o = 0, wr_pulse_o = 0;
  - all valids = 0, write_resp = 0, read_data = 0, read_resp = 0;
  - both slots emptied; all readies high the next cycle.
- Reset mid-transaction discards buffered AW/W and any pending B/R response; no partial register update.
- Write latency: last of AW/W handshaken at edge E → commit at E+1 (regs_o updated, write_resp_valid high) → B handshake at earliest E+2. Max throughput is one write per 2 cycles.
- If B is stalled, slots stay full and the readies stay low; no second commit happens until B completes.
- Read latency: AR handshake at edge E → read_data_valid high after E. Max one read per 2 cycles.
- Read and write paths are fully independent; both may progress in the same cycle.

## Structure
- Package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - a clog2 function;
  - helper functions for the index/range check.
- Sub-module axi_lite_hold_slot: a parametrised one-entry valid/ready holding register, instantiated for AW (ADDR_W) and W (DATA_W + DATA_W/8).
- Top level holds the decode, register array, B/R output registers and pulse logic.

## Test plan
All scenarios use DATA_W=32, NUM_REGS=8, RO_MASK=8'h80.
- AW 0x04 and W 0xDEADBEEF, strb 4'hF, both in the same cycle → regs_o[63:32]=0xDEADBEEF, write_resp=00 one cycle later, wr_pulse_o=8'h02 for one cycle; read of 0x04 returns 0xDEADBEEF/OKAY.
- W sent 3 cycles before AW 0x08, strb 4'b0101, data 0x11223344, register preset to 0xFFFFFFFF → register becomes 0xFF22FF44; write_addr_ready stays high until AW arrives.
- Write to 0x1C (RO) and to 0x20 (out of range) → both return SLVERR, regs_o unchanged, no pulse. Reading 0x1C with status_i[255:224]=0xCAFE0001 returns 0xCAFE0001/OKAY; reading 0x20 returns 0/SLVERR.
- write_resp_ready held low for 5 cycles after a write, and a second AW+W is offered → second write is not committed and the readies stay low until B completes; the second commit follows one cycle later.
- Same-edge AR 0x00 and commit of 0x5 to 0x00 (old value 0x0) → read_data=0x0; a subsequent read returns 0x5. read_data_ready held low for 4 cycles → R outputs stay stable.
- rst_i asserted with AW buffered and R pending → the next cycle shows all valids 0, readies high, regs_o=0; a write after reset completes normally.
